chg_event_gen: RTL and testbench

//  Programmable level-change stimulus generator: the driving end of the change-detect/expect protocol.

---
 rtl/chg_event_gen_pkg.sv | 18 +
 rtl/chg_event_gen_if.sv | 23 ++
 rtl/chg_event_gen_dly_cnt.sv | 27 ++
 rtl/chg_event_gen.sv | 108 ++++++++++
 tb/tb_chg_event_gen.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chg_event_gen_pkg.sv
// Shared types and helpers for the programmable level-change stimulus generator.
package chg_event_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chg_gen_state_e;

  localparam int unsigned DLY_W_DEF = 8;

  // Largest delay a DLY_W-bit command can request.
  function automatic int unsigned max_delay(input int unsigned dly_w);
    return (32'd1 << dly_w) - 32'd1;
  endfunction

  localparam int unsigned MAX_DELAY_DEF = max_delay(DLY_W_DEF);

endpackage

// File: rtl/chg_event_gen_if.sv
// Command channel of chg_event_gen: valid/ready handshake carrying delay and value, plus abort.
interface chg_event_gen_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DLY_W = 8
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [DLY_W-1:0] cmd_delay;
  logic [WIDTH-1:0] cmd_value;
  logic             cmd_abort;

  modport master (
    output cmd_valid, cmd_delay, cmd_value, cmd_abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_delay, cmd_value, cmd_abort,
    output cmd_ready
  );

endinterface

// File: rtl/chg_event_gen_dly_cnt.sv
// Loadable down-counter that times the wait between command accept and apply.
module chg_event_gen_dly_cnt #(
  parameter int unsigned DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - DLY_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/chg_event_gen.sv
// Programmable level-change stimulus generator: applies a commanded value after a programmed delay.
// Optional change counter (evt_count) is built when CHG_EVENT_GEN_CNT_EN is defined.
module chg_event_gen
  import chg_event_gen_pkg::*;
#(
  parameter int unsigned      WIDTH    = 1,
  parameter int unsigned      DLY_W    = DLY_W_DEF,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
`ifdef CHG_EVENT_GEN_CNT_EN
  , parameter int unsigned    CNT_W    = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  chg_event_gen_if.slave   cmd_if,
  output logic [WIDTH-1:0] sig_out,
  output logic             done,
  output logic             aborted,
  output logic             evt_pulse
`ifdef CHG_EVENT_GEN_CNT_EN
  , output logic [CNT_W-1:0] evt_count
`endif
);

  chg_gen_state_e   state;
  chg_gen_state_e   state_nxt;
  logic [WIDTH-1:0] val_q;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_en;
  logic             apply_c;
  logic             abort_c;
  logic             chg_c;

  chg_event_gen_dly_cnt #(
    .DLY_W (DLY_W)
  ) u_dly_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cmd_if.cmd_delay),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort takes priority over an apply that falls due in the same cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (cmd_if.cmd_valid) state_nxt = WAIT;
      WAIT: if (cmd_if.cmd_abort || cnt_zero) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    apply_c  = 1'b0;
    abort_c  = 1'b0;
    unique case (state)
      IDLE: cnt_load = cmd_if.cmd_valid;
      WAIT: begin
        abort_c = cmd_if.cmd_abort;
        apply_c = !cmd_if.cmd_abort && cnt_zero;
        cnt_en  = !cmd_if.cmd_abort;
      end
    endcase
  end

  assign cmd_if.cmd_ready = (state == IDLE);
  assign chg_c            = (val_q != sig_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_out   <= INIT_VAL;
      val_q     <= INIT_VAL;
      done      <= 1'b0;
      aborted   <= 1'b0;
      evt_pulse <= 1'b0;
    end else begin
      done      <= apply_c;
      aborted   <= abort_c;
      evt_pulse <= apply_c && chg_c;
      if (apply_c) sig_out <= val_q;
      if (cnt_load) val_q <= cmd_if.cmd_value;
    end
  end

`ifdef CHG_EVENT_GEN_CNT_EN
  // Saturating count of real changes; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count <= '0;
    end else if (apply_c && chg_c && (evt_count != '1)) begin
      evt_count <= evt_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_chg_event_gen.sv
// Directed bench for chg_event_gen with a timestamp-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_chg_event_gen;
  import chg_event_gen_pkg::*;

  localparam int unsigned      WIDTH    = 1;
  localparam int unsigned      DLY_W    = DLY_W_DEF;
  localparam logic [WIDTH-1:0] INIT_VAL = '0;
`ifdef CHG_EVENT_GEN_CNT_EN
  localparam int unsigned      CNT_W    = 2;
  logic [CNT_W-1:0] evt_count;
  int               exp_cnt;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sig_out;
  logic             done;
  logic             aborted;
  logic             evt_pulse;

  chg_event_gen_if #(.WIDTH(WIDTH), .DLY_W(DLY_W)) cmd_if ();

  chg_event_gen #(
    .WIDTH    (WIDTH),
    .DLY_W    (DLY_W),
    .INIT_VAL (INIT_VAL)
`ifdef CHG_EVENT_GEN_CNT_EN
    , .CNT_W  (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_if    (cmd_if),
    .sig_out   (sig_out),
    .done      (done),
    .aborted   (aborted),
    .evt_pulse (evt_pulse)
`ifdef CHG_EVENT_GEN_CNT_EN
    , .evt_count (evt_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Reference model: a pending command is remembered with the absolute edge at which it falls due.
  bit               chk_en = 1'b0;
  bit               pend   = 1'b0;
  logic [WIDTH-1:0] pval;
  int               due;
  logic [WIDTH-1:0] exp_sig;
  bit               exp_done, exp_ab, exp_evt;

  always @(posedge clk) begin
    cyc++;
    exp_done = 1'b0;
    exp_ab   = 1'b0;
    exp_evt  = 1'b0;
    if (rst) begin
      pend    = 1'b0;
      exp_sig = INIT_VAL;
      chk_en  = 1'b1;
`ifdef CHG_EVENT_GEN_CNT_EN
      exp_cnt = 0;
`endif
    end else if (pend) begin
      if (cmd_if.cmd_abort) begin
        pend   = 1'b0;
        exp_ab = 1'b1;
      end else if (cyc == due) begin
        pend     = 1'b0;
        exp_done = 1'b1;
        exp_evt  = (pval != exp_sig);
        exp_sig  = pval;
`ifdef CHG_EVENT_GEN_CNT_EN
        if (exp_evt && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
`endif
      end
    end else if (cmd_if.cmd_valid) begin
      pend = 1'b1;
      pval = cmd_if.cmd_value;
      due  = cyc + int'(cmd_if.cmd_delay) + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_sig_out", 32'(sig_out), 32'(exp_sig));
      chk("m_ready", 32'(cmd_if.cmd_ready), 32'(!pend));
      chk("m_done", 32'(done), 32'(exp_done));
      chk("m_aborted", 32'(aborted), 32'(exp_ab));
      chk("m_evt_pulse", 32'(evt_pulse), 32'(exp_evt));
`ifdef CHG_EVENT_GEN_CNT_EN
      chk("m_evt_count", 32'(evt_count), 32'(exp_cnt));
`endif
    end
  end

  // Offer a command, return at the negedge just after the accept edge with acc = that edge's index.
  task automatic send(input int d, input logic [WIDTH-1:0] v, input bit ab, output int acc);
    int n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_delay = DLY_W'(d);
    cmd_if.cmd_value = v;
    cmd_if.cmd_abort = ab;
    while (!cmd_if.cmd_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) timeout("send_ready");
    @(negedge clk);
    acc = cyc;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_delay = '1;
    cmd_if.cmd_value = ~v;
    cmd_if.cmd_abort = 1'b0;
    chk("ready_after_accept", 32'(cmd_if.cmd_ready), 32'(0));
  endtask

  // Wait for done or aborted; count WAIT cycles with cmd_ready low seen on the way.
  task automatic wait_end(output int at, output int lows, output bit was_done);
    int n = 0;
    lows = 0;
    at = -1;
    was_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done || aborted) begin
        at = cyc;
        was_done = done;
        break;
      end
      if (!cmd_if.cmd_ready) lows++;
      n++;
      if (n > 400) begin
        timeout("wait_end");
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int acc, acc2, at, lows, ndone;
  bit wd;
  int exp6[5] = '{1, 2, 3, 3, 3};

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_delay = '0;
    cmd_if.cmd_value = '0;
    cmd_if.cmd_abort = 1'b0;

    // Test 1: reset held three cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_sig_out", 32'(sig_out), 32'(0));
    chk("t1_ready", 32'(cmd_if.cmd_ready), 32'(1));
    chk("t1_pulses", 32'({done, aborted, evt_pulse}), 32'(0));
    rst = 1'b0;

    // Test 2: delay 9, value 1
    send(9, 1'b1, 1'b0, acc);
    wait_end(at, lows, wd);
    chk("t2_latency", 32'(at - acc), 32'(10));
    chk("t2_ready_low", 32'(lows), 32'(9));
    chk("t2_done", 32'(wd), 32'(1));
    chk("t2_evt", 32'(evt_pulse), 32'(1));
    chk("t2_sig_out", 32'(sig_out), 32'(1));
    @(negedge clk);
    chk("t2_done_1cyc", 32'({done, evt_pulse}), 32'(0));

    // Test 3: delay 0, same value
    send(0, 1'b1, 1'b0, acc);
    wait_end(at, lows, wd);
    chk("t3_latency", 32'(at - acc), 32'(1));
    chk("t3_done", 32'(done), 32'(1));
    chk("t3_evt", 32'(evt_pulse), 32'(0));
    chk("t3_sig_out", 32'(sig_out), 32'(1));

    // Test 4a: abort in the third WAIT cycle of a delay-5 command
    send(5, 1'b0, 1'b0, acc);
    repeat (2) @(negedge clk);
    cmd_if.cmd_abort = 1'b1;
    @(negedge clk);
    cmd_if.cmd_abort = 1'b0;
    chk("t4_aborted", 32'(aborted), 32'(1));
    chk("t4_no_done", 32'(done), 32'(0));
    chk("t4_sig_out", 32'(sig_out), 32'(1));
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("t4_no_late_done", 32'(ndone), 32'(0));

    // Test 4b: abort exactly when the count has reached zero
    send(2, 1'b0, 1'b0, acc);
    repeat (2) @(negedge clk);
    cmd_if.cmd_abort = 1'b1;
    wait_end(at, lows, wd);
    cmd_if.cmd_abort = 1'b0;
    chk("t4b_at", 32'(at - acc), 32'(3));
    chk("t4b_aborted", 32'(aborted), 32'(1));
    chk("t4b_was_done", 32'(wd), 32'(0));
    chk("t4b_sig_out", 32'(sig_out), 32'(1));

    // Test 4c: abort while idle does not block the accept
    send(1, 1'b0, 1'b1, acc);
    wait_end(at, lows, wd);
    chk("t4c_latency", 32'(at - acc), 32'(2));
    chk("t4c_done", 32'(wd), 32'(1));
    chk("t4c_sig_out", 32'(sig_out), 32'(0));
    chk("t4c_evt", 32'(evt_pulse), 32'(1));

    // Back-to-back commands: accepts are delay+2 apart
    send(3, 1'b1, 1'b0, acc);
    send(3, 1'b0, 1'b0, acc2);
    chk("b2b_spacing", 32'(acc2 - acc), 32'(5));
    chk("b2b_first_applied", 32'(sig_out), 32'(1));
    wait_end(at, lows, wd);
    chk("b2b_second_sig", 32'(sig_out), 32'(0));

    // Test 5: reset in the middle of a long wait
    send(20, 1'b1, 1'b0, acc);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_sig_out", 32'(sig_out), 32'(0));
    chk("t5_ready", 32'(cmd_if.cmd_ready), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || aborted || evt_pulse) ndone++;
    end
    chk("t5_no_pulses", 32'(ndone), 32'(0));
    send(0, 1'b1, 1'b0, acc);
    wait_end(at, lows, wd);
    chk("t5_new_latency", 32'(at - acc), 32'(1));
    chk("t5_new_sig", 32'(sig_out), 32'(1));

    // Test 6: five alternating commands from a fresh reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, acc);
      wait_end(at, lows, wd);
      chk("t6_evt", 32'(evt_pulse), 32'(1));
      chk("t6_sig_out", 32'(sig_out), 32'((i % 2 == 0) ? 1 : 0));
`ifdef CHG_EVENT_GEN_CNT_EN
      chk("t6_evt_count", 32'(evt_count), 32'(exp6[i]));
`endif
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
